// File: rtl/spi_pixel_master.sv
// SPI mode-0 master for the FPGA pixel-injection port.
// Runs 3-byte register/command transactions and, in stream mode, sends
// 6-byte pixel-pair groups while returning every slave byte to the host.
// Chip select is active high; the slave is held in reset while css is low.
module spi_pixel_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4,
    parameter int CNT_W   = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_addr,
    input  logic [7:0]       cmd_wdata,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [47:0]      pix_data,
    output logic             rsp_valid,
    output logic [7:0]       rsp_data,
    output logic             rsp_last,
    output logic             sck,
    output logic             css,
    output logic             mosi,
    input  logic             miso,
    output logic             busy
);

    localparam int DIV_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int DIV_W   = $clog2(DIV_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(CS_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] OP_WRREG   = 3'd0;
    localparam logic [2:0] OP_RDREG   = 3'd1;
    localparam logic [2:0] OP_SCR_CLR = 3'd2;
    localparam logic [2:0] OP_SCR_SET = 3'd3;
    localparam logic [2:0] OP_STREAM  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_NEXT  = 3'd3,
        S_HOLD  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    // Three header bytes for a command, first byte in [23:16].
    function automatic logic [23:0] build_header(input logic [2:0] op,
                                                 input logic [7:0] addr,
                                                 input logic [7:0] wdata);
        logic [23:0] hdr;
        case (op)
            OP_WRREG:   hdr = {8'h80, addr, wdata};
            OP_RDREG:   hdr = {8'h81, addr, 8'h00};
            OP_SCR_CLR: hdr = {8'h40, 8'h00, 8'h00};
            OP_SCR_SET: hdr = {8'h41, 8'h00, 8'h00};
            OP_STREAM:  hdr = {8'h55, 8'h00, 8'h00};
            default:    hdr = 24'h000000;
        endcase
        return hdr;
    endfunction

    state_t           r_state,     w_state_nxt;
    logic [DIV_W-1:0] r_div,       w_div_nxt;
    logic [2:0]       r_bit,       w_bit_nxt;
    logic [2:0]       r_idx,       w_idx_nxt;
    logic             r_sck,       w_sck_nxt;
    logic             r_css,       w_css_nxt;
    logic             r_mosi,      w_mosi_nxt;
    logic [7:0]       r_tx,        w_tx_nxt;
    logic [7:0]       r_rx,        w_rx_nxt;
    logic [39:0]      r_pair,      w_pair_nxt;
    logic [2:0]       r_op,        w_op_nxt;
    logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic             r_in_hdr,    w_in_hdr_nxt;
    logic             r_need_pair, w_need_pair_nxt;
    logic             r_stall,     w_stall_nxt;
    logic             r_pix_ready, w_pix_ready_nxt;
    logic             r_rsp_valid, w_rsp_valid_nxt;
    logic [7:0]       r_rsp_data,  w_rsp_data_nxt;
    logic             r_rsp_last,  w_rsp_last_nxt;
    logic             r_busy,      w_busy_nxt;
    logic             r_cmd_ready, w_cmd_ready_nxt;

    logic [23:0]      w_hdr;
    logic             w_div_end;
    logic             w_gap_end;
    logic             w_take;

    assign w_hdr     = build_header(cmd_op, cmd_addr, cmd_wdata);
    assign w_div_end = (r_div == DIV_LAST);
    assign w_gap_end = (r_div == GAP_LAST);

    // Next-state and next-output logic for the whole transfer engine.
    always_comb begin
        w_state_nxt     = r_state;
        w_div_nxt       = r_div;
        w_bit_nxt       = r_bit;
        w_idx_nxt       = r_idx;
        w_sck_nxt       = r_sck;
        w_css_nxt       = r_css;
        w_mosi_nxt      = r_mosi;
        w_tx_nxt        = r_tx;
        w_rx_nxt        = r_rx;
        w_pair_nxt      = r_pair;
        w_op_nxt        = r_op;
        w_cnt_nxt       = r_cnt;
        w_in_hdr_nxt    = r_in_hdr;
        w_need_pair_nxt = r_need_pair;
        w_stall_nxt     = r_stall;
        w_pix_ready_nxt = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_last_nxt  = 1'b0;
        w_busy_nxt      = r_busy;
        w_cmd_ready_nxt = 1'b0;
        w_take          = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cmd_ready_nxt = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_cmd_ready_nxt = 1'b0;
                    w_busy_nxt      = 1'b1;
                    w_op_nxt        = cmd_op;
                    w_cnt_nxt       = cmd_len;
                    w_div_nxt       = DIV_ZERO;
                    if (cmd_op > OP_STREAM) begin
                        // Reserved opcode: answer with 0xFF, never touch the bus.
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_data_nxt  = 8'hFF;
                        w_rsp_last_nxt  = 1'b1;
                        w_state_nxt     = S_GAP;
                    end else begin
                        w_css_nxt       = 1'b1;
                        w_tx_nxt        = w_hdr[23:16];
                        w_pair_nxt      = {w_hdr[15:0], 24'h000000};
                        w_bit_nxt       = 3'd0;
                        w_idx_nxt       = 3'd0;
                        w_in_hdr_nxt    = 1'b1;
                        w_need_pair_nxt = 1'b0;
                        w_stall_nxt     = 1'b0;
                        w_state_nxt     = S_SETUP;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_SETUP: begin
                if (w_div_end) begin
                    // Present the first bit a full half-period before the first rise.
                    w_div_nxt   = DIV_ZERO;
                    w_mosi_nxt  = r_tx[7];
                    w_tx_nxt    = {r_tx[6:0], 1'b0};
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_div_nxt = r_div + DIV_ONE;
                end
            end

            S_SHIFT: begin
                if (r_stall) begin
                    // sck parked low, css high, until a whole pair is available.
                    if (pix_valid) begin
                        w_take = 1'b1;
                    end else begin
                        w_div_nxt = DIV_ZERO;
                    end
                end else if (w_div_end) begin
                    w_div_nxt = DIV_ZERO;
                    if (!r_sck) begin
                        w_sck_nxt = 1'b1;
                        w_rx_nxt  = {r_rx[6:0], miso};
                        w_bit_nxt = r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            w_state_nxt = S_NEXT;
                        end else begin
                            w_state_nxt = S_SHIFT;
                        end
                    end else begin
                        w_sck_nxt = 1'b0;
                        if (r_need_pair) begin
                            if (pix_valid) begin
                                w_take = 1'b1;
                            end else begin
                                w_stall_nxt = 1'b1;
                            end
                        end else begin
                            w_mosi_nxt = r_tx[7];
                            w_tx_nxt   = {r_tx[6:0], 1'b0};
                        end
                    end
                end else begin
                    w_div_nxt = r_div + DIV_ONE;
                end
            end

            S_NEXT: begin
                // One cycle inside the high phase of the 8th bit: pick the next byte.
                w_div_nxt = r_div + DIV_ONE;
                if (r_in_hdr) begin
                    if (r_idx != 3'd2) begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_tx_nxt    = r_pair[39:32];
                        w_pair_nxt  = {r_pair[31:0], 8'h00};
                        w_state_nxt = S_SHIFT;
                    end else begin
                        if (r_op == OP_RDREG) begin
                            w_rsp_valid_nxt = 1'b1;
                            w_rsp_data_nxt  = r_rx;
                            w_rsp_last_nxt  = 1'b1;
                        end else begin
                            w_rsp_valid_nxt = 1'b0;
                        end
                        if ((r_op == OP_STREAM) && (r_cnt != CNT_ZERO)) begin
                            w_in_hdr_nxt    = 1'b0;
                            w_idx_nxt       = 3'd0;
                            w_need_pair_nxt = 1'b1;
                            w_state_nxt     = S_SHIFT;
                        end else begin
                            w_state_nxt = S_HOLD;
                        end
                    end
                end else begin
                    // Stream byte: slave data is forwarded as-is.
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = r_rx;
                    if (r_idx != 3'd5) begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_tx_nxt    = r_pair[39:32];
                        w_pair_nxt  = {r_pair[31:0], 8'h00};
                        w_state_nxt = S_SHIFT;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                        if (r_cnt == CNT_ONE) begin
                            w_rsp_last_nxt = 1'b1;
                            w_state_nxt    = S_HOLD;
                        end else begin
                            w_idx_nxt       = 3'd0;
                            w_need_pair_nxt = 1'b1;
                            w_state_nxt     = S_SHIFT;
                        end
                    end
                end
            end

            S_HOLD: begin
                if (w_div_end) begin
                    w_div_nxt = DIV_ZERO;
                    if (r_sck) begin
                        w_sck_nxt  = 1'b0;
                        w_mosi_nxt = 1'b0;
                    end else begin
                        // Dropping css also takes the slave out of stream mode.
                        w_css_nxt   = 1'b0;
                        w_state_nxt = S_GAP;
                    end
                end else begin
                    w_div_nxt = r_div + DIV_ONE;
                end
            end

            S_GAP: begin
                if (w_gap_end) begin
                    w_div_nxt       = DIV_ZERO;
                    w_busy_nxt      = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_div_nxt = r_div + DIV_ONE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_sck_nxt   = 1'b0;
                w_css_nxt   = 1'b0;
                w_mosi_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
                w_div_nxt   = DIV_ZERO;
            end
        endcase

        // Accept a pixel pair and launch its first bit in the same cycle.
        if (w_take) begin
            w_pix_ready_nxt = 1'b1;
            w_mosi_nxt      = pix_data[47];
            w_tx_nxt        = {pix_data[46:40], 1'b0};
            w_pair_nxt      = pix_data[39:0];
            w_stall_nxt     = 1'b0;
            w_need_pair_nxt = 1'b0;
            w_div_nxt       = DIV_ZERO;
        end else begin
            w_pix_ready_nxt = w_pix_ready_nxt;
        end
    end

    // State and output registers; reset aborts any transfer at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_div       <= DIV_ZERO;
            r_bit       <= 3'd0;
            r_idx       <= 3'd0;
            r_sck       <= 1'b0;
            r_css       <= 1'b0;
            r_mosi      <= 1'b0;
            r_tx        <= 8'h00;
            r_rx        <= 8'h00;
            r_pair      <= 40'h0;
            r_op        <= 3'd0;
            r_cnt       <= CNT_ZERO;
            r_in_hdr    <= 1'b0;
            r_need_pair <= 1'b0;
            r_stall     <= 1'b0;
            r_pix_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'h00;
            r_rsp_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div       <= w_div_nxt;
            r_bit       <= w_bit_nxt;
            r_idx       <= w_idx_nxt;
            r_sck       <= w_sck_nxt;
            r_css       <= w_css_nxt;
            r_mosi      <= w_mosi_nxt;
            r_tx        <= w_tx_nxt;
            r_rx        <= w_rx_nxt;
            r_pair      <= w_pair_nxt;
            r_op        <= w_op_nxt;
            r_cnt       <= w_cnt_nxt;
            r_in_hdr    <= w_in_hdr_nxt;
            r_need_pair <= w_need_pair_nxt;
            r_stall     <= w_stall_nxt;
            r_pix_ready <= w_pix_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_last  <= w_rsp_last_nxt;
            r_busy      <= w_busy_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign pix_ready = r_pix_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_last  = r_rsp_last;
    assign sck       = r_sck;
    assign css       = r_css;
    assign mosi      = r_mosi;
    assign busy      = r_busy;

endmodule

// File: tb/tb_spi_pixel_master.sv
// Directed bench for spi_pixel_master with a mode-0 slave model.
`timescale 1ns/1ps
module tb_spi_pixel_master;

    localparam int CLK_DIV = 4;
    localparam int CS_GAP  = 4;
    localparam int CNT_W   = 20;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = 3'd0;
    logic [7:0]       cmd_addr = 8'h00;
    logic [7:0]       cmd_wdata = 8'h00;
    logic [CNT_W-1:0] cmd_len = 20'd0;
    logic             pix_valid = 1'b0;
    logic             pix_ready;
    logic [47:0]      pix_data = 48'h0;
    logic             rsp_valid;
    logic [7:0]       rsp_data;
    logic             rsp_last;
    logic             sck;
    logic             css;
    logic             mosi;
    logic             miso = 1'b0;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mo_q[$];
    logic [7:0] rsp_d_q[$];
    logic       rsp_l_q[$];
    int         rise_q[$];
    int         pix_cnt = 0;
    int         css_hi  = 0;
    int         gap_cnt = 0;
    int         cyc     = 0;
    logic       sck_prev = 1'b0;
    logic [7:0] mo_sh = 8'h00;
    int         mo_n = 0;
    logic [7:0] s_cur = 8'h00;
    int         s_byte = 0;
    int         s_bit = 0;
    logic       stall_ok;

    spi_pixel_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .sck(sck), .css(css), .mosi(mosi), .miso(miso), .busy(busy)
    );

    always #5 clk = ~clk;

    // Slave return byte k of a transaction: 0x5A in byte 2, else 0xC0^k.
    function automatic logic [7:0] slave_ret(input int k);
        return (k == 2) ? 8'h5A : (8'hC0 ^ 8'(k));
    endfunction

    // Slave: first bit ready at css rise, next bit after each sck fall.
    always @(posedge css) begin
        s_byte = 0;
        s_bit  = 0;
        s_cur  = slave_ret(0);
        miso   = s_cur[7];
        mo_n   = 0;
    end

    always @(negedge sck) begin
        if (css) begin
            if (s_bit == 7) begin
                s_bit  = 0;
                s_byte = s_byte + 1;
                s_cur  = slave_ret(s_byte);
            end else begin
                s_bit = s_bit + 1;
            end
            miso = s_cur[7 - s_bit];
        end
    end

    // Slave: capture mosi on each sck rise.
    always @(posedge sck) begin
        if (css) begin
            mo_sh = {mo_sh[6:0], mosi};
            mo_n  = mo_n + 1;
            if (mo_n == 8) begin
                mo_q.push_back(mo_sh);
                mo_n = 0;
            end
        end
    end

    // Host-side monitor sampled mid-cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rsp_valid === 1'b1) begin
            rsp_d_q.push_back(rsp_data);
            rsp_l_q.push_back(rsp_last);
        end
        if (pix_ready === 1'b1) pix_cnt = pix_cnt + 1;
        if (css === 1'b1) css_hi = css_hi + 1;
        if (css === 1'b0 && busy === 1'b1) gap_cnt = gap_cnt + 1;
        if (sck === 1'b1 && sck_prev === 1'b0) rise_q.push_back(cyc);
        sck_prev = sck;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack_mo();
        logic [127:0] v = 128'h0;
        foreach (mo_q[i]) v = {v[119:0], mo_q[i]};
        return v;
    endfunction

    function automatic logic [127:0] pack_rsp();
        logic [127:0] v = 128'h0;
        foreach (rsp_d_q[i]) v = {v[119:0], rsp_d_q[i]};
        return v;
    endfunction

    function automatic logic [127:0] pack_last();
        logic [127:0] v = 128'h0;
        foreach (rsp_l_q[i]) v = {v[126:0], rsp_l_q[i]};
        return v;
    endfunction

    task automatic clr_mon();
        mo_q.delete();
        rsp_d_q.delete();
        rsp_l_q.delete();
        rise_q.delete();
        pix_cnt = 0;
        css_hi  = 0;
        gap_cnt = 0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d,
                         input logic [CNT_W-1:0] len);
        @(negedge clk);
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_len   = len;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!(cmd_ready === 1'b1 && busy === 1'b0) && n < 5000) begin
            @(negedge clk);
            n = n + 1;
        end
        chk({tag, "_done_timeout"}, 128'(n < 5000), 128'd1);
    endtask

    task automatic wait_pix(input string tag);
        int n = 0;
        @(negedge clk);
        while (pix_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n = n + 1;
        end
        chk({tag, "_pix_timeout"}, 128'(n < 3000), 128'd1);
    endtask

    task automatic wait_bytes(input string tag, input int k);
        int n = 0;
        while (mo_q.size() < k && n < 3000) begin
            @(negedge clk);
            n = n + 1;
        end
        chk({tag, "_byte_timeout"}, 128'(n < 3000), 128'd1);
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_outs", 128'({sck, css, mosi, cmd_ready, pix_ready, rsp_valid, rsp_last, busy}), 128'h00);
        chk("rst_rsp_data", 128'(rsp_data), 128'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_rst", 128'(cmd_ready), 128'd1);

        // WRREG addr 0x02 data 0x01
        clr_mon();
        issue(3'd0, 8'h02, 8'h01, 20'd0);
        wait_done("wr");
        chk("wr_nbytes", 128'(mo_q.size()), 128'd3);
        chk("wr_bytes", pack_mo(), 128'h800201);
        chk("wr_rises", 128'(rise_q.size()), 128'd24);
        chk("wr_css_hi", 128'(css_hi), 128'd200);
        chk("wr_rsp", 128'(rsp_d_q.size()), 128'd0);
        chk("wr_gap", 128'(gap_cnt), 128'd4);

        // RDREG addr 0x02, slave answers 0x5A in byte 3
        clr_mon();
        issue(3'd1, 8'h02, 8'h00, 20'd0);
        wait_done("rd");
        chk("rd_bytes", pack_mo(), 128'h810200);
        chk("rd_rsp_n", 128'(rsp_d_q.size()), 128'd1);
        chk("rd_rsp_data", pack_rsp(), 128'h5A);
        chk("rd_rsp_last", pack_last(), 128'h1);

        // STREAM len=2
        clr_mon();
        pix_data  = 48'h112233445566;
        pix_valid = 1'b1;
        issue(3'd4, 8'h00, 8'h00, 20'd2);
        wait_pix("st2_p0");
        pix_data = 48'hAABBCCDDEEFF;
        wait_pix("st2_p1");
        pix_valid = 1'b0;
        pix_data  = 48'h0;
        wait_done("st2");
        chk("st2_nbytes", 128'(mo_q.size()), 128'd15);
        chk("st2_bytes", pack_mo(), 128'h550000112233445566AABBCCDDEEFF);
        chk("st2_rsp_n", 128'(rsp_d_q.size()), 128'd12);
        chk("st2_rsp_data", pack_rsp(), 128'hC3C4C5C6C7C8C9CACBCCCDCE);
        chk("st2_rsp_last", pack_last(), 128'h001);
        chk("st2_pix_ready", 128'(pix_cnt), 128'd2);

        // STREAM len=1 with the pair withheld after the header
        clr_mon();
        pix_valid = 1'b0;
        issue(3'd4, 8'h00, 8'h00, 20'd1);
        wait_bytes("stall_hdr", 3);
        repeat (10) @(negedge clk);
        stall_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (!(sck === 1'b0 && css === 1'b1)) stall_ok = 1'b0;
            @(negedge clk);
        end
        chk("stall_frozen", 128'(stall_ok), 128'd1);
        chk("stall_rises", 128'(rise_q.size()), 128'd24);
        pix_data  = 48'h0123456789AB;
        pix_valid = 1'b1;
        wait_pix("stall_p0");
        pix_valid = 1'b0;
        wait_done("stall");
        chk("stall_bytes", pack_mo(), 128'h5500000123456789AB);
        chk("stall_rises_all", 128'(rise_q.size()), 128'd72);
        chk("stall_b2b_span", 128'(rise_q[71] - rise_q[24]), 128'd376);
        chk("stall_rsp_data", pack_rsp(), 128'hC3C4C5C6C7C8);
        chk("stall_rsp_last", pack_last(), 128'h01);
        chk("stall_pix_ready", 128'(pix_cnt), 128'd1);

        // SCR_SET then STREAM len=0
        clr_mon();
        issue(3'd3, 8'h00, 8'h00, 20'd0);
        wait_done("scr");
        chk("scr_bytes", pack_mo(), 128'h410000);
        chk("scr_gap", 128'(gap_cnt), 128'd4);
        chk("scr_rsp", 128'(rsp_d_q.size()), 128'd0);
        clr_mon();
        issue(3'd4, 8'h00, 8'h00, 20'd0);
        wait_done("st0");
        chk("st0_bytes", pack_mo(), 128'h550000);
        chk("st0_nbytes", 128'(mo_q.size()), 128'd3);
        chk("st0_rsp", 128'(rsp_d_q.size()), 128'd0);
        chk("st0_pix_ready", 128'(pix_cnt), 128'd0);
        chk("st0_css_hi", 128'(css_hi), 128'd200);

        // Reserved opcode
        clr_mon();
        issue(3'd6, 8'h12, 8'h34, 20'd0);
        wait_done("rsv");
        chk("rsv_rsp_data", pack_rsp(), 128'hFF);
        chk("rsv_rsp_last", pack_last(), 128'h1);
        chk("rsv_rises", 128'(rise_q.size()), 128'd0);
        chk("rsv_css_hi", 128'(css_hi), 128'd0);

        // Async reset in the middle of a stream byte
        clr_mon();
        pix_data  = 48'hDEADBEEF0102;
        pix_valid = 1'b1;
        issue(3'd4, 8'h00, 8'h00, 20'd1);
        wait_pix("rst_p0");
        pix_valid = 1'b0;
        wait_bytes("rst_mid", 4);
        repeat (26) @(negedge clk);
        chk("rst_pre_active", 128'({sck, css}), 128'h3);
        rst_n = 1'b0;
        #1;
        chk("rst_abort_pins", 128'({sck, css, mosi}), 128'h0);
        chk("rst_abort_flags", 128'({busy, rsp_valid, pix_ready}), 128'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clr_mon();
        repeat (3) @(negedge clk);
        chk("rst_ready_again", 128'({cmd_ready, busy}), 128'h2);
        repeat (20) @(negedge clk);
        chk("rst_no_stale_rsp", 128'(rsp_d_q.size()), 128'd0);
        chk("rst_no_activity", 128'(rise_q.size() + css_hi), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
